// File: rtl/etapa_mem.sv
// etapa_mem: RISC-V memory-access stage, req/ack data bus, MEM/WB register.
// Optional MISALIGN_DETECT_EN flags misaligned H/W accesses instead of issuing them.
module etapa_mem #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            validm_i,
    input  logic [XLEN-1:0] aluresultm_i,
    input  logic [XLEN-1:0] writedatam_i,
    input  logic [4:0]      rdm_i,
    input  logic [XLEN-1:0] pcplus4m_i,
    input  logic            memreadm_i,
    input  logic            memwritem_i,
    input  logic [2:0]      funct3m_i,
    input  logic            regwritem_i,
    input  logic [1:0]      resultsrcm_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic            validw_o,
    output logic [XLEN-1:0] readdataw_o,
    output logic [XLEN-1:0] aluresultw_o,
    output logic [4:0]      rdw_o,
    output logic [XLEN-1:0] pcplus4w_o,
    output logic            regwritew_o,
    output logic [1:0]      resultsrcw_o,
    output logic            misalign_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] h_addr_q, h_wdata_q, h_alu_q, h_pc_q;
    logic [3:0]      h_be_q;
    logic            h_we_q, h_rw_q;
    logic [2:0]      h_f3_q;
    logic [4:0]      h_rd_q;
    logic [1:0]      h_rs_q;

    logic            in_wait, memop, nonmem, mis, ack;
    logic [1:0]      off_in;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in, addr_in;

    logic [2:0]      sel_f3;
    logic [1:0]      sel_off;
    logic [XLEN-1:0] sel_alu, sel_pc, ext_data;
    logic [4:0]      sel_rd;
    logic            sel_rw;
    logic [1:0]      sel_rs;

    logic            wb_valid_d, wb_rw_d, wb_mis_d;

    assign in_wait = (state_q == WAIT);
    assign off_in  = aluresultm_i[1:0];
    assign addr_in = {aluresultm_i[XLEN-1:2], 2'b00};
    assign nonmem  = validm_i & ~(memreadm_i | memwritem_i);

`ifdef MISALIGN_DETECT_EN
    assign mis = validm_i & (memreadm_i | memwritem_i) &
                 (((funct3m_i[1:0] == 2'b01) & aluresultm_i[0]) |
                  ((funct3m_i[1:0] == 2'b10) & (off_in != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    assign memop = validm_i & (memreadm_i | memwritem_i) & ~mis;

    // Byte lanes and replicated store data for the incoming access
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = writedatam_i;
        case (funct3m_i[1:0])
            2'b00: begin
                be_in    = 4'b0001 << off_in;
                wdata_in = {4{writedatam_i[7:0]}};
            end
            2'b01: begin
                be_in    = 4'b0011 << {off_in[1], 1'b0};
                wdata_in = {2{writedatam_i[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = writedatam_i;
            end
        endcase
    end

    assign dmem_req_o   = reset_i & (in_wait | memop);
    assign ack          = dmem_req_o & dmem_ack_i;
    assign stall_o      = dmem_req_o & ~dmem_ack_i;
    assign dmem_we_o    = dmem_req_o & (in_wait ? h_we_q : memwritem_i);
    assign dmem_addr_o  = dmem_req_o ? (in_wait ? h_addr_q : addr_in) : '0;
    assign dmem_be_o    = dmem_req_o ? (in_wait ? h_be_q : be_in) : 4'b0000;
    assign dmem_wdata_o = dmem_req_o ? (in_wait ? h_wdata_q : wdata_in) : '0;

    assign sel_f3  = in_wait ? h_f3_q : funct3m_i;
    assign sel_off = in_wait ? h_alu_q[1:0] : off_in;
    assign sel_alu = in_wait ? h_alu_q : aluresultm_i;
    assign sel_pc  = in_wait ? h_pc_q : pcplus4m_i;
    assign sel_rd  = in_wait ? h_rd_q : rdm_i;
    assign sel_rw  = in_wait ? h_rw_q : regwritem_i;
    assign sel_rs  = in_wait ? h_rs_q : resultsrcm_i;

    // Load extraction: pick byte/half by offset, then sign or zero extend
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b        = dmem_rdata_i[7:0];
        h        = sel_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        ext_data = dmem_rdata_i;
        case (sel_off)
            2'b00:   b = dmem_rdata_i[7:0];
            2'b01:   b = dmem_rdata_i[15:8];
            2'b10:   b = dmem_rdata_i[23:16];
            default: b = dmem_rdata_i[31:24];
        endcase
        case (sel_f3[1:0])
            2'b00:   ext_data = sel_f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   ext_data = sel_f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: ext_data = dmem_rdata_i;
        endcase
    end

    // MEM/WB valid, write-enable and misalign flag for this cycle
    always_comb begin
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_mis_d   = 1'b0;
        if (ack) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = sel_rw;
        end else if (!in_wait && nonmem) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = regwritem_i;
        end else if (!in_wait && mis) begin
            wb_valid_d = 1'b1;
            wb_mis_d   = 1'b1;
        end
    end

    // Next state: park in WAIT until the bus acknowledges
    always_comb begin
        state_d = state_q;
        if (!in_wait && memop && !dmem_ack_i) state_d = WAIT;
        if (in_wait && dmem_ack_i)             state_d = IDLE;
    end

    // State register and holding registers for an outstanding access
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            h_addr_q  <= '0;
            h_wdata_q <= '0;
            h_alu_q   <= '0;
            h_pc_q    <= '0;
            h_be_q    <= '0;
            h_we_q    <= 1'b0;
            h_rw_q    <= 1'b0;
            h_f3_q    <= '0;
            h_rd_q    <= '0;
            h_rs_q    <= '0;
        end else begin
            state_q <= state_d;
            if (!in_wait && memop && !dmem_ack_i) begin
                h_addr_q  <= addr_in;
                h_wdata_q <= wdata_in;
                h_alu_q   <= aluresultm_i;
                h_pc_q    <= pcplus4m_i;
                h_be_q    <= be_in;
                h_we_q    <= memwritem_i;
                h_rw_q    <= regwritem_i;
                h_f3_q    <= funct3m_i;
                h_rd_q    <= rdm_i;
                h_rs_q    <= resultsrcm_i;
            end
        end
    end

    // MEM/WB pipeline register; load data only updates on completion
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            validw_o     <= 1'b0;
            regwritew_o  <= 1'b0;
            misalign_o   <= 1'b0;
            readdataw_o  <= '0;
            aluresultw_o <= '0;
            rdw_o        <= '0;
            pcplus4w_o   <= '0;
            resultsrcw_o <= '0;
        end else begin
            validw_o     <= wb_valid_d;
            regwritew_o  <= wb_rw_d;
            misalign_o   <= wb_mis_d;
            aluresultw_o <= sel_alu;
            rdw_o        <= sel_rd;
            pcplus4w_o   <= sel_pc;
            resultsrcw_o <= sel_rs;
            if (ack) readdataw_o <= ext_data;
        end
    end

endmodule

// File: tb/tb_etapa_mem.sv
// tb_etapa_mem: directed checks of etapa_mem loads, stores, stalls, reset.
// Inputs change at negedge; outputs sampled 1ns later or 1ns after posedge.
module tb_etapa_mem;

    logic        clk_i, reset_i;
    logic        validm_i, memreadm_i, memwritem_i, regwritem_i;
    logic [31:0] aluresultm_i, writedatam_i, pcplus4m_i;
    logic [4:0]  rdm_i;
    logic [2:0]  funct3m_i;
    logic [1:0]  resultsrcm_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_be_o;
    logic        stall_o, validw_o, regwritew_o, misalign_o;
    logic [31:0] readdataw_o, aluresultw_o, pcplus4w_o;
    logic [4:0]  rdw_o;
    logic [1:0]  resultsrcw_o;

    int checks = 0;
    int failures = 0;

    etapa_mem #(.XLEN(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .validm_i(validm_i), .aluresultm_i(aluresultm_i),
        .writedatam_i(writedatam_i), .rdm_i(rdm_i),
        .pcplus4m_i(pcplus4m_i), .memreadm_i(memreadm_i),
        .memwritem_i(memwritem_i), .funct3m_i(funct3m_i),
        .regwritem_i(regwritem_i), .resultsrcm_i(resultsrcm_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
        .validw_o(validw_o), .readdataw_o(readdataw_o),
        .aluresultw_o(aluresultw_o), .rdw_o(rdw_o),
        .pcplus4w_o(pcplus4w_o), .regwritew_o(regwritew_o),
        .resultsrcw_o(resultsrcw_o), .misalign_o(misalign_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        validm_i     = 1'b0;
        memreadm_i   = 1'b0;
        memwritem_i  = 1'b0;
        regwritem_i  = 1'b0;
        aluresultm_i = '0;
        writedatam_i = '0;
        pcplus4m_i   = '0;
        rdm_i        = '0;
        funct3m_i    = '0;
        resultsrcm_i = '0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
    endtask

    task automatic edge_wait();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        clr();
        reset_i = 1'b0;
        #1;
        chk("rst_req", dmem_req_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_validw", validw_o, 1'b0);
        chk("rst_misalign", misalign_o, 1'b0);
        chk("rst_readdata", readdataw_o, 32'h0);
        chk("rst_addr", dmem_addr_o, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b1;

        // LB 0x103, same-cycle ack
        @(negedge clk_i);
        validm_i = 1; memreadm_i = 1; funct3m_i = 3'b000;
        aluresultm_i = 32'h103; rdm_i = 5; regwritem_i = 1;
        resultsrcm_i = 2'b01; pcplus4m_i = 32'h1004;
        dmem_ack_i = 1; dmem_rdata_i = 32'h80AABBCC;
        #1;
        chk("lb_req", dmem_req_o, 1'b1);
        chk("lb_stall", stall_o, 1'b0);
        chk("lb_addr", dmem_addr_o, 32'h100);
        chk("lb_be", dmem_be_o, 4'b1000);
        chk("lb_we", dmem_we_o, 1'b0);
        edge_wait();
        chk("lb_validw", validw_o, 1'b1);
        chk("lb_rdata", readdataw_o, 32'hFFFFFF80);
        chk("lb_rd", rdw_o, 5'd5);
        chk("lb_rw", regwritew_o, 1'b1);
        chk("lb_rs", resultsrcw_o, 2'b01);
        chk("lb_pc", pcplus4w_o, 32'h1004);

        // LHU 0x102, ack after 3 wait cycles
        @(negedge clk_i);
        funct3m_i = 3'b101; aluresultm_i = 32'h102; rdm_i = 7;
        dmem_ack_i = 0; dmem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("lhu_stall0", stall_o, 1'b1);
        chk("lhu_addr0", dmem_addr_o, 32'h100);
        chk("lhu_be0", dmem_be_o, 4'b1100);
        edge_wait();
        chk("lhu_bub0", validw_o, 1'b0);
        chk("lhu_bubrw0", regwritew_o, 1'b0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk_i);
            aluresultm_i = 32'h3FF; funct3m_i = 3'b010; rdm_i = 9;
            #1;
            chk("lhu_stall", stall_o, 1'b1);
            chk("lhu_addr", dmem_addr_o, 32'h100);
            chk("lhu_be", dmem_be_o, 4'b1100);
            chk("lhu_req", dmem_req_o, 1'b1);
            edge_wait();
            chk("lhu_bub", validw_o, 1'b0);
        end
        @(negedge clk_i);
        dmem_ack_i = 1; dmem_rdata_i = 32'h80011234;
        #1;
        chk("lhu_ackstall", stall_o, 1'b0);
        chk("lhu_ackreq", dmem_req_o, 1'b1);
        edge_wait();
        chk("lhu_validw", validw_o, 1'b1);
        chk("lhu_rdata", readdataw_o, 32'h00008001);
        chk("lhu_rd", rdw_o, 5'd7);
        chk("lhu_rw", regwritew_o, 1'b1);

        // SB 0x101
        @(negedge clk_i);
        clr();
        validm_i = 1; memwritem_i = 1; funct3m_i = 3'b000;
        aluresultm_i = 32'h101; writedatam_i = 32'h12345678;
        dmem_ack_i = 1;
        #1;
        chk("sb_be", dmem_be_o, 4'b0010);
        chk("sb_wdata", dmem_wdata_o, 32'h78787878);
        chk("sb_addr", dmem_addr_o, 32'h100);
        chk("sb_we", dmem_we_o, 1'b1);
        chk("sb_stall", stall_o, 1'b0);
        edge_wait();
        chk("sb_validw", validw_o, 1'b1);
        chk("sb_rw", regwritew_o, 1'b0);

        // SH 0x102
        @(negedge clk_i);
        funct3m_i = 3'b001; aluresultm_i = 32'h102;
        #1;
        chk("sh_be", dmem_be_o, 4'b1100);
        chk("sh_wdata", dmem_wdata_o, 32'h56785678);

        // valid non-memory instruction
        @(negedge clk_i);
        clr();
        validm_i = 1; aluresultm_i = 32'hDEAD0001; rdm_i = 3;
        regwritem_i = 1;
        #1;
        chk("alu_req", dmem_req_o, 1'b0);
        chk("alu_stall", stall_o, 1'b0);
        edge_wait();
        chk("alu_validw", validw_o, 1'b1);
        chk("alu_res", aluresultw_o, 32'hDEAD0001);
        chk("alu_rd", rdw_o, 5'd3);
        chk("alu_rw", regwritew_o, 1'b1);

        // stray ack with nothing outstanding
        @(negedge clk_i);
        clr();
        dmem_ack_i = 1;
        #1;
        chk("stray_req", dmem_req_o, 1'b0);
        edge_wait();
        chk("stray_validw", validw_o, 1'b0);

        // LH signed 0x000, LBU 0x001
        @(negedge clk_i);
        clr();
        validm_i = 1; memreadm_i = 1; funct3m_i = 3'b001;
        aluresultm_i = 32'h0; dmem_ack_i = 1; dmem_rdata_i = 32'h1234F00D;
        edge_wait();
        chk("lh_rdata", readdataw_o, 32'hFFFFF00D);
        @(negedge clk_i);
        funct3m_i = 3'b100; aluresultm_i = 32'h1; dmem_rdata_i = 32'h00008100;
        edge_wait();
        chk("lbu_rdata", readdataw_o, 32'h00000081);

        // reset asserted while in WAIT
        @(negedge clk_i);
        clr();
        validm_i = 1; memreadm_i = 1; funct3m_i = 3'b010;
        aluresultm_i = 32'h40; rdm_i = 4; regwritem_i = 1;
        #1;
        chk("wr_stall0", stall_o, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("wr_req_wait", dmem_req_o, 1'b1);
        #1;
        reset_i = 1'b0;
        #1;
        chk("wr_req", dmem_req_o, 1'b0);
        chk("wr_stall", stall_o, 1'b0);
        chk("wr_validw", validw_o, 1'b0);
        @(negedge clk_i);
        clr();
        reset_i = 1'b1;
        @(negedge clk_i);
        validm_i = 1; memreadm_i = 1; funct3m_i = 3'b010;
        aluresultm_i = 32'h44; rdm_i = 6; regwritem_i = 1;
        dmem_ack_i = 1; dmem_rdata_i = 32'hCAFEBABE;
        #1;
        chk("wr_lw_req", dmem_req_o, 1'b1);
        chk("wr_lw_addr", dmem_addr_o, 32'h44);
        chk("wr_lw_stall", stall_o, 1'b0);
        edge_wait();
        chk("wr_lw_validw", validw_o, 1'b1);
        chk("wr_lw_rdata", readdataw_o, 32'hCAFEBABE);

        // LW at misaligned 0x202
        @(negedge clk_i);
        clr();
        validm_i = 1; memreadm_i = 1; funct3m_i = 3'b010;
        aluresultm_i = 32'h202; regwritem_i = 1;
        dmem_ack_i = 1; dmem_rdata_i = 32'h11223344;
        #1;
`ifdef MISALIGN_DETECT_EN
        chk("mis_req", dmem_req_o, 1'b0);
        chk("mis_stall", stall_o, 1'b0);
        edge_wait();
        chk("mis_validw", validw_o, 1'b1);
        chk("mis_flag", misalign_o, 1'b1);
        chk("mis_rw", regwritew_o, 1'b0);
`else
        chk("mis_req", dmem_req_o, 1'b1);
        chk("mis_addr", dmem_addr_o, 32'h200);
        chk("mis_be", dmem_be_o, 4'b1111);
        edge_wait();
        chk("mis_validw", validw_o, 1'b1);
        chk("mis_flag", misalign_o, 1'b0);
        chk("mis_rdata", readdataw_o, 32'h11223344);
`endif

        @(negedge clk_i);
        clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
